pipe_skid_reg: RTL and testbench

Parametrised pipeline-stage register, the successor to the fixed-field inter-stage registers of the core (IF/ID, ID/EX, EX/MEM). It carries an opaque payload between two stages using a valid/ready handshake instead of the global stall vector, and inserts a configurable NOP payload on reset, flush and drain. An optional skid entry registers the backpressure path (`ready_o`), so long stall chains do not form combinational loops across stages.

---
 rtl/pipe_skid_reg_pkg.sv | 25 ++
 rtl/pipe_skid_buf.sv | 52 +++++
 rtl/pipe_skid_reg.sv | 121 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline-stage skid register.
// Holds the stage state encoding and a helper that maps a state to the
// number of entries it holds.
package pipe_skid_reg_pkg;

  localparam int unsigned PsrOccW = 2;

  typedef enum logic [1:0] {
    PsrEmpty = 2'd0,
    PsrFull  = 2'd1,
    PsrSkid  = 2'd2
  } psr_state_e;

  function automatic logic [PsrOccW-1:0] psr_occupancy(input psr_state_e st);
    logic [PsrOccW-1:0] occ;
    occ = 2'd0;
    case (st)
      PsrFull: occ = 2'd1;
      PsrSkid: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry for pipe_skid_reg: one payload slot plus its valid bit.
// Ports:
//   clk_i, n_rst_i (synchronous, active-low; clears contents to NOP_PAYLOAD)
//   clear_i  - drop the held entry (flush)
//   load_i   - capture data_i and mark valid
//   unload_i - mark the entry consumed
//   data_i / data_o - payload in / held payload
//   valid_o  - entry held
module pipe_skid_buf #(
  parameter int unsigned           PAYLOAD_W   = 64,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic                 unload_i,
  input  logic [PAYLOAD_W-1:0] data_i,
  output logic [PAYLOAD_W-1:0] data_o,
  output logic                 valid_o
);

  logic [PAYLOAD_W-1:0] data_d, data_q;
  logic                 valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      data_q  <= NOP_PAYLOAD;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and NOP insertion.
// Optional feature macro: PIPE_SKID_REG_SKID_EN adds a skid entry so that
// ready_o is a pure register decode (no combinational path from ready_i).
// Ports:
//   clk_i, n_rst_i (synchronous, active-low), flush_i (kills held entries)
//   valid_i / ready_o / payload_i     - upstream handshake
//   valid_o / ready_i / payload_o     - downstream handshake, payload registered
//   occupancy_o                       - entries held (0..2 with skid, 0..1 without)
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned           PAYLOAD_W   = 64,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [1:0]           occupancy_o
);

  psr_state_e           state_d, state_q;
  logic [PAYLOAD_W-1:0] main_d, main_q;
  logic                 in_xfer, out_xfer;

  assign valid_o  = (state_q != PsrEmpty);
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

`ifdef PIPE_SKID_REG_SKID_EN
  logic                 skid_load, skid_unload, skid_valid;
  logic [PAYLOAD_W-1:0] skid_data;

  // skid_valid is set exactly in PsrSkid, so this is a flop decode.
  assign ready_o = ~skid_valid;

  pipe_skid_buf #(
    .PAYLOAD_W  (PAYLOAD_W),
    .NOP_PAYLOAD(NOP_PAYLOAD)
  ) u_skid (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .clear_i (flush_i),
    .load_i  (skid_load),
    .unload_i(skid_unload),
    .data_i  (payload_i),
    .data_o  (skid_data),
    .valid_o (skid_valid)
  );
`else
  assign ready_o = ~valid_o | ready_i;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_REG_SKID_EN
    skid_load   = 1'b0;
    skid_unload = 1'b0;
`endif
    if (flush_i) begin
      // Any accepted upstream entry and the skid entry are dropped.
      state_d = PsrEmpty;
      main_d  = NOP_PAYLOAD;
    end else begin
      case (state_q)
        PsrEmpty: begin
          if (in_xfer) begin
            state_d = PsrFull;
            main_d  = payload_i;
          end
        end
        PsrFull: begin
          if (in_xfer && out_xfer) begin
            main_d = payload_i;
          end else if (out_xfer) begin
            state_d = PsrEmpty;
            main_d  = NOP_PAYLOAD;
          end else if (in_xfer) begin
`ifdef PIPE_SKID_REG_SKID_EN
            state_d   = PsrSkid;
            skid_load = 1'b1;
`endif
          end
        end
`ifdef PIPE_SKID_REG_SKID_EN
        PsrSkid: begin
          if (ready_i) begin
            state_d     = PsrFull;
            main_d      = skid_data;
            skid_unload = 1'b1;
          end
        end
`endif
        default: begin
          state_d = PsrEmpty;
          main_d  = NOP_PAYLOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q <= PsrEmpty;
      main_q  <= NOP_PAYLOAD;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  assign payload_o   = main_q;
  assign occupancy_o = psr_occupancy(state_q);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (both build variants).
module tb_pipe_skid_reg;

  localparam int unsigned W   = 64;
  localparam logic [W-1:0] NOP = 64'h0000_0000_0000_0013;

  logic         clk;
  logic         n_rst;
  logic         flush;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] payload_in;
  logic         valid_out;
  logic         ready_in;
  logic [W-1:0] payload_out;
  logic [1:0]   occ;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_skid_reg #(
    .PAYLOAD_W  (W),
    .NOP_PAYLOAD(NOP)
  ) dut (
    .clk_i      (clk),
    .n_rst_i    (n_rst),
    .flush_i    (flush),
    .valid_i    (valid_in),
    .ready_o    (ready_out),
    .payload_i  (payload_in),
    .valid_o    (valid_out),
    .ready_i    (ready_in),
    .payload_o  (payload_out),
    .occupancy_o(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then driven/sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [W-1:0] p,
                           input logic [1:0] o);
    chk({tag, ".valid"}, W'(valid_out), W'(v));
    chk({tag, ".payload"}, payload_out, p);
    chk({tag, ".occ"}, W'(occ), W'(o));
  endtask

  initial begin
    n_rst = 1'b0; flush = 1'b0; valid_in = 1'b1; payload_in = 64'hAA; ready_in = 1'b1;
    tick();
    tick();
    chk_state("reset", 1'b0, NOP, 2'd0);
    chk("reset.ready", W'(ready_out), W'(1'b1));

    // Streaming 1,2,3
    n_rst = 1'b1; valid_in = 1'b1; payload_in = 64'd1;
    tick();
    chk_state("stream1", 1'b1, 64'd1, 2'd1);
    payload_in = 64'd2;
    tick();
    chk_state("stream2", 1'b1, 64'd2, 2'd1);
    payload_in = 64'd3;
    tick();
    chk_state("stream3", 1'b1, 64'd3, 2'd1);
    valid_in = 1'b0; payload_in = 64'h77;
    tick();
    chk_state("stream_end", 1'b0, NOP, 2'd0);
    // payload_i ignored when valid_i=0
    tick();
    chk_state("idle_ignore", 1'b0, NOP, 2'd0);

    // Drain single entry 0x20
    valid_in = 1'b1; payload_in = 64'h20;
    tick();
    chk_state("drain_load", 1'b1, 64'h20, 2'd1);
    valid_in = 1'b0;
    tick();
    chk_state("drain", 1'b0, NOP, 2'd0);
    chk("drain.ready", W'(ready_out), W'(1'b1));

    // Backpressure
    valid_in = 1'b1; payload_in = 64'h10; ready_in = 1'b1;
    tick();
    chk_state("bp_load", 1'b1, 64'h10, 2'd1);
    ready_in = 1'b0; payload_in = 64'h11;
    #1;
`ifdef PIPE_SKID_REG_SKID_EN
    chk("bp.ready_full", W'(ready_out), W'(1'b1));
    tick();
    chk_state("bp_skid", 1'b1, 64'h10, 2'd2);
    chk("bp.ready_skid", W'(ready_out), W'(1'b0));
    // Offered while ready_o=0: must never enter.
    payload_in = 64'h12; ready_in = 1'b1;
    tick();
    chk_state("bp_out1", 1'b1, 64'h11, 2'd1);
    valid_in = 1'b0;
    tick();
    chk_state("bp_out2", 1'b0, NOP, 2'd0);
`else
    chk("bp.ready_comb", W'(ready_out), W'(1'b0));
    valid_in = 1'b1; payload_in = 64'h99;
    tick();
    chk_state("bp_hold", 1'b1, 64'h10, 2'd1);
    payload_in = 64'h11; ready_in = 1'b1;
    #1;
    chk("bp.ready_release", W'(ready_out), W'(1'b1));
    tick();
    chk_state("bp_next", 1'b1, 64'h11, 2'd1);
    valid_in = 1'b0;
    tick();
    chk_state("bp_drain", 1'b0, NOP, 2'd0);
`endif

    // Flush while stalled (SKID state in skid build)
    valid_in = 1'b1; payload_in = 64'h50; ready_in = 1'b1;
    tick();
    ready_in = 1'b0; payload_in = 64'h51;
    tick();
`ifdef PIPE_SKID_REG_SKID_EN
    chk("flush.pre_occ", W'(occ), W'(2'd2));
`else
    chk("flush.pre_occ", W'(occ), W'(2'd1));
`endif
    flush = 1'b1; payload_in = 64'h55;
    tick();
    chk_state("flush_stall", 1'b0, NOP, 2'd0);
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    tick();
    chk_state("flush_after", 1'b0, NOP, 2'd0);

    // Flush with ready_o=1: offered entry is discarded
    valid_in = 1'b1; payload_in = 64'h31;
    tick();
    flush = 1'b1; payload_in = 64'h56;
    tick();
    chk_state("flush_accept", 1'b0, NOP, 2'd0);
    flush = 1'b0; valid_in = 1'b0;
    tick();
    chk_state("flush_gone", 1'b0, NOP, 2'd0);

    // Reset together with flush while holding an entry
    valid_in = 1'b1; payload_in = 64'h40; ready_in = 1'b0;
    tick();
    chk_state("rst_pre", 1'b1, 64'h40, 2'd1);
    n_rst = 1'b0; flush = 1'b1;
    tick();
    chk_state("rst_flush", 1'b0, NOP, 2'd0);
    chk("rst_flush.ready", W'(ready_out), W'(1'b1));
    n_rst = 1'b1; flush = 1'b0; valid_in = 1'b0;
    tick();
    chk_state("rst_after", 1'b0, NOP, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
